// File: rtl/rescale_line_buffer.sv
// Source-row ring buffer feeding four bilinear neighbours to the rescale core.
// Define RESCALE_LB_TLAST_CHECK_EN to flag TLAST that disagrees with the column count.
module rescale_line_buffer #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int NROWS = 3
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic [15:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  input  logic        in_stream_ready,
  input  logic [8:0]  row_to_wait,
  input  logic [10:0] neighbor_offset,
  output logic        buffer_done,
  output logic [15:0] neighbor0,
  output logic [15:0] neighbor1,
  output logic [15:0] neighbor2,
  output logic [15:0] neighbor3,
  output logic        lb_error
);

  localparam int DEPTH = NROWS * SRC_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int SLW   = $clog2(NROWS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL, S_DONE} state_t;

  state_t         r_state;
  logic [9:0]     r_w;
  logic [9:0]     r_col;
  logic [SLW-1:0] r_slot;
  logic           r_done;
  logic           r_err;
  logic [15:0]    r_nb0, r_nb1, r_nb2, r_nb3;
  logic [15:0]    r_mem [DEPTH];

  logic           w_hs, w_row_end, w_range_ok, w_stale, w_done_nx, w_tlast_err;
  logic [10:0]    w_r, w_r1, w_ww, w_c1, w_d, w_d0, w_s, w_sr;
  logic [SLW-1:0] w_slot_r, w_slot_r1, w_slot_nx;
  logic [AW-1:0]  w_waddr, w_a0, w_a1, w_a2, w_a3;
  logic [15:0]    w_rd0, w_rd1, w_rd2, w_rd3;

  function automatic logic [AW-1:0] addr_of(input logic [SLW-1:0] s, input logic [10:0] c);
    return AW'(int'(s) * SRC_W + int'(c));
  endfunction

  assign S_AXIS_TREADY = (r_state == S_FILL);
  assign w_hs      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_row_end = (r_col == 10'(SRC_W - 1));

  assign w_r  = {2'b00, row_to_wait};
  assign w_ww = {1'b0, r_w};
  assign w_r1 = (w_r < 11'(SRC_H - 1)) ? w_r + 11'd1 : w_r;
  assign w_c1 = (neighbor_offset < 11'(SRC_W - 1)) ? neighbor_offset + 11'd1 : neighbor_offset;

  assign w_range_ok = (neighbor_offset < 11'(SRC_W)) && (w_r < 11'(SRC_H));
  assign w_stale    = w_ww > w_r + 11'(NROWS);
  assign w_done_nx  = (w_ww > w_r1) && !w_stale;

  // Slot of row R is found by stepping back (w - R) slots from the write slot.
  assign w_d       = w_ww - w_r;
  assign w_d0      = (w_d <= 11'(NROWS)) ? w_d : 11'd0;
  assign w_s       = {{(11-SLW){1'b0}}, r_slot};
  assign w_sr      = (w_s >= w_d0) ? w_s - w_d0 : w_s + 11'(NROWS) - w_d0;
  assign w_slot_r  = w_sr[SLW-1:0];
  assign w_slot_r1 = (w_r1 == w_r) ? w_slot_r :
                     ((w_slot_r == SLW'(NROWS - 1)) ? '0 : w_slot_r + SLW'(1));
  assign w_slot_nx = (r_slot == SLW'(NROWS - 1)) ? '0 : r_slot + SLW'(1);

  assign w_waddr = addr_of(r_slot, {1'b0, r_col});
  assign w_a0    = addr_of(w_slot_r,  neighbor_offset);
  assign w_a1    = addr_of(w_slot_r,  w_c1);
  assign w_a2    = addr_of(w_slot_r1, neighbor_offset);
  assign w_a3    = addr_of(w_slot_r1, w_c1);

  // Write-first: a beat landing on a read address is forwarded directly.
  assign w_rd0 = (w_hs && w_a0 == w_waddr) ? S_AXIS_TDATA : r_mem[w_a0];
  assign w_rd1 = (w_hs && w_a1 == w_waddr) ? S_AXIS_TDATA : r_mem[w_a1];
  assign w_rd2 = (w_hs && w_a2 == w_waddr) ? S_AXIS_TDATA : r_mem[w_a2];
  assign w_rd3 = (w_hs && w_a3 == w_waddr) ? S_AXIS_TDATA : r_mem[w_a3];

`ifdef RESCALE_LB_TLAST_CHECK_EN
  assign w_tlast_err = w_hs && (S_AXIS_TLAST != w_row_end);
`else
  logic w_unused_tlast;
  assign w_unused_tlast = S_AXIS_TLAST;
  assign w_tlast_err    = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (w_hs) r_mem[w_waddr] <= S_AXIS_TDATA;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_col   <= '0;
      r_slot  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_nb0   <= '0;
      r_nb1   <= '0;
      r_nb2   <= '0;
      r_nb3   <= '0;
    end else if (!in_stream_ready) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_col   <= '0;
      r_slot  <= '0;
      r_done  <= 1'b0;
      r_nb0   <= '0;
      r_nb1   <= '0;
      r_nb2   <= '0;
      r_nb3   <= '0;
    end else begin
      r_done <= w_done_nx;
      if (w_stale || !w_range_ok || w_tlast_err) r_err <= 1'b1;
      if (w_range_ok) begin
        r_nb0 <= w_rd0;
        r_nb1 <= w_rd1;
        r_nb2 <= w_rd2;
        r_nb3 <= w_rd3;
      end
      case (r_state)
        S_IDLE: r_state <= S_FILL;
        S_FILL: begin
          if (w_hs) begin
            if (w_row_end) begin
              r_col  <= '0;
              r_w    <= r_w + 10'd1;
              r_slot <= w_slot_nx;
              if (w_ww + 11'd1 == 11'(SRC_H))             r_state <= S_DONE;
              else if (w_ww + 11'd1 >= w_r + 11'(NROWS))  r_state <= S_FULL;
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end
        S_FULL: if (w_ww < w_r + 11'(NROWS)) r_state <= S_FILL;
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign buffer_done = r_done;
  assign lb_error    = r_err;
  assign neighbor0   = r_nb0;
  assign neighbor1   = r_nb1;
  assign neighbor2   = r_nb2;
  assign neighbor3   = r_nb3;

endmodule

// File: doc/rescale_line_buffer.md
Name: rescale_line_buffer

Overview:
- Input-side responder to the rescale core's neighbor-request interface.
- Accepts a source RGB565 frame on an AXI4-Stream slave, one pixel per beat, into a ring of NROWS source rows.
- Asserts buffer_done once the requested source rows are resident.
- Returns the four bilinear neighbors (r,c), (r,c+1), (r+1,c), (r+1,c+1) for the requested row/column.

Parameters:
SRC_W, 320, source image width in pixels (max 1024)
SRC_H, 240, source image height in rows (max 512)
NROWS, 3, number of row slots in ring buffer (>=2)

Ports:
CLOCK  in  1  system clock, all logic rising-edge
RESETN  in  1  reset; synchronous, active-low
S_AXIS_TDATA  in  16  source pixel, RGB565
S_AXIS_TVALID  in  1  source beat valid
S_AXIS_TLAST  in  1  end of source row
S_AXIS_TREADY  out  1  block accepts beat
in_stream_ready  in  1  core frame-active; low = idle, frame counters cleared
row_to_wait  in  9  requested window top source row R
neighbor_offset  in  11  requested source column C
buffer_done  out  1  rows R and min(R+1,SRC_H-1) resident
neighbor0  out  16  pixel (R,C)
neighbor1  out  16  pixel (R,min(C+1,SRC_W-1))
neighbor2  out  16  pixel (min(R+1,SRC_H-1),C)
neighbor3  out  16  pixel (min(R+1,SRC_H-1),min(C+1,SRC_W-1))
lb_error  out  1  sticky error flag

Behaviour:
- Reset (RESETN low at edge): state IDLE; S_AXIS_TREADY=0, buffer_done=0, neighbor0..3=0, lb_error=0; write row w=0, write col=0; RAM contents not cleared.
- Storage: pixel (row k, col j) at slot k mod NROWS, address slot*SRC_W+j. Single write port, four registered read ports (or equivalent banking).
- FSM:
  - IDLE: TREADY=0. in_stream_ready=1 -> FILL.
  - FILL: TREADY=1. Handshake = TVALID&TREADY. Each handshake writes a pixel and increments col. At col=SRC_W-1: col->0, w->w+1.
    - If w+1 == SRC_H -> FRAME_DONE.
    - Else if w+1 >= R+NROWS -> FULL.
  - FULL: TREADY=0. When w < R+NROWS (core advanced R) -> FILL next cycle.
  - FRAME_DONE: TREADY=0; all rows written.
  - Any state: in_stream_ready=0 -> IDLE next cycle; clear w, col, buffer_done, neighbors. Mid-row data is discarded; lb_error unaffected.
- Overwrite protection: never accept a beat whose row would evict row R (w < R+NROWS required). TREADY is deasserted combinationally-safe: derived from registered state/counters only, with no dependency on TVALID.
- buffer_done: registered. Next value = in_stream_ready & (w > min(R+1,SRC_H-1)) & (R >= w-NROWS, clamped at 0 when w<NROWS). Rises 1 cycle after the completing row's last beat. Falls 1 cycle after R changes to an unsatisfied row.
- Stale request: if R < w-NROWS (row already evicted), buffer_done stays 0 and lb_error sets. lb_error is cleared only by reset.
- Out-of-range request: C >= SRC_W or R >= SRC_H -> lb_error sets; neighbors hold their previous values.
- Neighbor read: 1-cycle latency. neighbor0..3 reflect R and C sampled at edge n and are valid after edge n+1. Valid only while buffer_done=1. Clamp rules apply at the right and bottom edges.
- Simultaneous events:
  - A write to the last beat of a row and a read of that row in the same cycle return the new data on the next cycle (write-first).
  - R advancing in the same cycle FULL evaluates: the new R is used.
- Arithmetic: w is 10 bits, col is 10 bits, all compares unsigned, slot index via modulo counter (no divider).

Optional Feature:
- Macro RESCALE_LB_TLAST_CHECK_EN.
- Defined: on a handshake, TLAST must equal (col==SRC_W-1). Any mismatch sets lb_error; the pixel is still written and counters advance per column count (TLAST is not used for resync).
- Undefined: TLAST is ignored entirely; lb_error is driven only by stale/out-of-range requests.

Test Plan:
- Reset then in_stream_ready=1, stream rows 0-1 (pixel value = row*SRC_W+col), R=0 -> buffer_done=1 one cycle after beat 639. C=5 gives neighbor0=5, neighbor1=6, neighbor2=325, neighbor3=326.
- Continuous TVALID with R held at 0, NROWS=3 -> TREADY drops after beat 959 (w=3). R=1 -> TREADY=1 next cycle, row 3 is written to slot 0.
- R=239, C=319 after full frame -> all four neighbors = pixel(239,319)=76799; state FRAME_DONE; TREADY=0.
- After w=5, set R=1 -> buffer_done=0 and lb_error=1. Then RESETN low for one cycle -> all outputs 0.
- Drop in_stream_ready mid-row 10 col 100, then raise it again -> next beat is stored as (0,0); buffer_done=0 until row 1 completes.
- RESCALE_LB_TLAST_CHECK_EN defined: TLAST=1 at col 318 -> lb_error=1 next cycle. Undefined: same stimulus -> lb_error stays 0.
